huedeon_gpu_ctrl2: RTL and testbench

Second-generation GPU front-end. It sits between the CPU register bus and the triangle raster engine. It double-buffers the three-vertex register set so the CPU can stage the next triangle while the current one rasterises, and it queues one pending draw. It also clips and pipelines framebuffer pixel writes and applies display-offset flips on vsync. The raster engine is external; this block drives it through ports.

---
 rtl/huedeon_pkg.sv | 75 +++++++
 rtl/huedeon_pix_clip.sv | 54 +++++
 rtl/huedeon_gpu_ctrl2.sv | 176 +++++++++++++++++
 tb/tb_huedeon_gpu_ctrl2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/huedeon_pkg.sv
// Shared constants for the Huedeon gen-2 GPU front-end: register map, vertex
// record layout, FSM encoding and status bit positions.
package huedeon_pkg;

    localparam int unsigned FIX_W   = 32;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned UV_W    = 12;
    localparam int unsigned COLOR_W = 32;
    localparam int unsigned VREC_W  = 3*FIX_W + 56;

    localparam int unsigned REG_RESET      = 0;
    localparam int unsigned REG_CONTROL    = 1;
    localparam int unsigned REG_DRAW       = 2;
    localparam int unsigned REG_VTX0       = 3;
    localparam int unsigned VTX_STRIDE     = 5;
    localparam int unsigned REG_DRAW_OFF   = 18;
    localparam int unsigned REG_DISP_OFF   = 19;

    // Record layout, LSB first: x, y, z, u, v, r, g, b, a (colour is the top 32 bits)
    localparam int unsigned X_OFF = 0;
    localparam int unsigned Y_OFF = FIX_W;
    localparam int unsigned Z_OFF = 2*FIX_W;
    localparam int unsigned U_OFF = 3*FIX_W;
    localparam int unsigned V_OFF = U_OFF + UV_W;
    localparam int unsigned R_OFF = V_OFF + UV_W;
    localparam int unsigned G_OFF = R_OFF + 8;
    localparam int unsigned B_OFF = G_OFF + 8;
    localparam int unsigned A_OFF = B_OFF + 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KICK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_ACTIVE   = 1;
    localparam int unsigned STAT_DONE     = 2;
    localparam int unsigned STAT_PENDING  = 3;
    localparam int unsigned STAT_OVERFLOW = 4;

    // Field 0..4 = X, Y, Z, COLOR {a,r,g,b}, UV {u,v}; u/v keep the low UV_W bits of each half.
    function automatic logic [VREC_W-1:0] vrec_write(input logic [VREC_W-1:0] rec,
                                                     input logic [2:0]        field,
                                                     input logic [31:0]       data);
        logic [VREC_W-1:0] r;
        r = rec;
        case (field)
            3'd0: r[X_OFF +: FIX_W] = FIX_W'(data);
            3'd1: r[Y_OFF +: FIX_W] = FIX_W'(data);
            3'd2: r[Z_OFF +: FIX_W] = FIX_W'(data);
            3'd3: begin
                r[A_OFF +: 8] = data[31:24];
                r[R_OFF +: 8] = data[23:16];
                r[G_OFF +: 8] = data[15:8];
                r[B_OFF +: 8] = data[7:0];
            end
            3'd4: begin
                r[U_OFF +: UV_W] = data[16 +: UV_W];
                r[V_OFF +: UV_W] = data[0 +: UV_W];
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [VREC_W-1:0] strip_colour(input logic [VREC_W-1:0] rec);
        logic [VREC_W-1:0] r;
        r = rec;
        r[R_OFF +: COLOR_W] = '0;
        return r;
    endfunction

endpackage

// File: rtl/huedeon_pix_clip.sv
// Framebuffer pixel stage: clips engine pixels to the screen and registers the
// linear address and colour for a one-cycle write.
module huedeon_pix_clip
    import huedeon_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned ADDR_W    = 18
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   base_i,
    input  logic [COORD_W-1:0]  x_i,
    input  logic [COORD_W-1:0]  y_i,
    input  logic [7:0]          r_i,
    input  logic [7:0]          g_i,
    input  logic [7:0]          b_i,
    input  logic                write_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [7:0]          r_o,
    output logic [7:0]          g_o,
    output logic [7:0]          b_o
);

    localparam int unsigned SUM_W = ADDR_W + COORD_W;

    logic             keep_c;
    logic [SUM_W-1:0] sum_c;

    // Sign bit excludes negatives, so the upper bounds can compare unsigned.
    always_comb begin
        keep_c = write_i && !x_i[COORD_W-1] && !y_i[COORD_W-1]
                 && (x_i < COORD_W'(FB_WIDTH)) && (y_i < COORD_W'(FB_HEIGHT));
        sum_c  = SUM_W'(base_i) + SUM_W'(y_i) * SUM_W'(FB_WIDTH) + SUM_W'(x_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_o <= 1'b0;
            addr_o  <= '0;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
        end else begin
            wr_en_o <= keep_c;
            addr_o  <= sum_c[ADDR_W-1:0];
            r_o     <= r_i;
            g_o     <= g_i;
            b_o     <= b_i;
        end
    end

endmodule

// File: rtl/huedeon_gpu_ctrl2.sv
// Huedeon gen-2 GPU front-end: CPU register decode, staged/pending/active vertex
// banks, draw sequencing for the raster engine, pixel writes and display flips.
module huedeon_gpu_ctrl2
    import huedeon_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned ADDR_W    = 18
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic                   i_chip_select,
    input  logic                   i_wr_enable,
    input  logic [31:0]            i_wr_address,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_vsync,
    output logic [31:0]            o_status,
    output logic [ADDR_W-1:0]      o_display_offset,
    output logic                   o_tre_reset,
    output logic                   o_tre_draw,
    output logic [3*VREC_W-1:0]    o_vtx,
    input  logic [COORD_W-1:0]     i_tre_x,
    input  logic [COORD_W-1:0]     i_tre_y,
    input  logic [7:0]             i_tre_r,
    input  logic [7:0]             i_tre_g,
    input  logic [7:0]             i_tre_b,
    input  logic                   i_tre_write,
    input  logic                   i_tre_busy,
    input  logic                   i_tre_done,
    output logic                   o_wr_enable,
    output logic [ADDR_W-1:0]      o_wr_address,
    output logic [7:0]             o_r,
    output logic [7:0]             o_g,
    output logic [7:0]             o_b
);

    state_e                   state_q;
    logic [1:0]               ctrl_q;
    logic [ADDR_W-1:0]        draw_off_q, pend_off_q, active_off_q;
    logic [ADDR_W-1:0]        disp_q, disp_shadow_q;
    logic [2:0][VREC_W-1:0]   stage_q, pend_q, active_q;
    logic                     pending_q, overflow_q, done_q, busy_q;
    logic                     tre_reset_q, tre_draw_q;

    logic                     wr_c, rst_c, commit_c;
    logic                     wr_reset_c, wr_ctrl_c, wr_draw_c, wr_draw_off_c, wr_disp_c;
    logic [2:0][VREC_W-1:0]   commit_bank_c;
    logic [31:0]              status_c;

    assign wr_c          = i_enable & i_chip_select & i_wr_enable;
    assign wr_reset_c    = wr_c && (i_wr_address == 32'(REG_RESET));
    assign wr_ctrl_c     = wr_c && (i_wr_address == 32'(REG_CONTROL));
    assign wr_draw_c     = wr_c && (i_wr_address == 32'(REG_DRAW));
    assign wr_draw_off_c = wr_c && (i_wr_address == 32'(REG_DRAW_OFF));
    assign wr_disp_c     = wr_c && (i_wr_address == 32'(REG_DISP_OFF));
    assign rst_c         = !i_reset_n || (wr_reset_c && i_wr_data[0]);
    assign commit_c      = (state_q == ST_IDLE) && pending_q;

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            commit_bank_c[n] = ctrl_q[0] ? pend_q[n] : strip_colour(pend_q[n]);
        end
    end

    always_comb begin
        status_c                = '0;
        status_c[STAT_BUSY]     = busy_q;
        status_c[STAT_ACTIVE]   = (state_q != ST_IDLE);
        status_c[STAT_DONE]     = done_q;
        status_c[STAT_PENDING]  = pending_q;
        status_c[STAT_OVERFLOW] = overflow_q;
    end

    always_ff @(posedge i_clk) begin
        if (rst_c) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= '0;
            draw_off_q    <= '0;
            pend_off_q    <= '0;
            active_off_q  <= '0;
            disp_q        <= '0;
            disp_shadow_q <= '0;
            stage_q       <= '0;
            pend_q        <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            tre_reset_q   <= 1'b1;
            tre_draw_q    <= 1'b0;
        end else begin
            tre_reset_q <= 1'b0;
            tre_draw_q  <= 1'b0;
            busy_q      <= i_tre_busy;

            if (wr_ctrl_c)     ctrl_q     <= i_wr_data[1:0];
            if (wr_draw_off_c) draw_off_q <= i_wr_data[ADDR_W-1:0];

            // In flip mode vsync publishes the shadow as it stood before this edge.
            if (wr_disp_c) begin
                disp_shadow_q <= i_wr_data[ADDR_W-1:0];
                if (!ctrl_q[1]) disp_q <= i_wr_data[ADDR_W-1:0];
            end
            if (ctrl_q[1] && i_vsync) disp_q <= disp_shadow_q;

            for (int v = 0; v < 3; v++) begin
                for (int f = 0; f < 5; f++) begin
                    if (wr_c && (i_wr_address == 32'(REG_VTX0 + v*VTX_STRIDE + f)))
                        stage_q[v] <= vrec_write(stage_q[v], 3'(f), i_wr_data);
                end
            end

            if (wr_draw_c || wr_reset_c) done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        active_q     <= commit_bank_c;
                        active_off_q <= pend_off_q;
                        pending_q    <= 1'b0;
                        tre_draw_q   <= 1'b1;
                        state_q      <= ST_KICK;
                    end
                end
                ST_KICK:  state_q <= ST_RUN;
                ST_RUN:   if (i_tre_done) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase

            // A DRAW landing on the commit edge refills the slot being vacated.
            if (wr_draw_c) begin
                if (!pending_q || commit_c) begin
                    pend_q     <= stage_q;
                    pend_off_q <= draw_off_q;
                    pending_q  <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign o_status         = status_c;
    assign o_display_offset = disp_q;
    assign o_tre_reset      = tre_reset_q;
    assign o_tre_draw       = tre_draw_q;
    assign o_vtx            = active_q;

    huedeon_pix_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_pix_clip (
        .clk_i   (i_clk),
        .rst_i   (rst_c),
        .base_i  (active_off_q),
        .x_i     (i_tre_x),
        .y_i     (i_tre_y),
        .r_i     (i_tre_r),
        .g_i     (i_tre_g),
        .b_i     (i_tre_b),
        .write_i (i_tre_write),
        .wr_en_o (o_wr_enable),
        .addr_o  (o_wr_address),
        .r_o     (o_r),
        .g_o     (o_g),
        .b_o     (o_b)
    );

endmodule

// File: tb/tb_huedeon_gpu_ctrl2.sv
// Directed bench for huedeon_gpu_ctrl2: draw sequencing, pending/overflow,
// pixel clipping, display flips and soft reset.
module tb_huedeon_gpu_ctrl2;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_enable = 1'b0, i_chip_select = 1'b0, i_wr_enable = 1'b0;
    logic [31:0]  i_wr_address = '0, i_wr_data = '0;
    logic         i_vsync = 1'b0;
    logic [31:0]  o_status;
    logic [17:0]  o_display_offset;
    logic         o_tre_reset, o_tre_draw;
    logic [455:0] o_vtx;
    logic [15:0]  i_tre_x = '0, i_tre_y = '0;
    logic [7:0]   i_tre_r = '0, i_tre_g = '0, i_tre_b = '0;
    logic         i_tre_write = 1'b0, i_tre_busy = 1'b0, i_tre_done = 1'b0;
    logic         o_wr_enable;
    logic [17:0]  o_wr_address;
    logic [7:0]   o_r, o_g, o_b;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] SEED_A = 32'h1000_0000;
    localparam logic [31:0] SEED_B = 32'h2200_0000;
    localparam logic [31:0] SEED_C = 32'h3300_0000;
    localparam logic [31:0] SEED_D = 32'h4400_0000;
    localparam logic [31:0] SEED_E = 32'h5500_0000;

    always #5 i_clk = ~i_clk;

    huedeon_gpu_ctrl2 dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_enable(i_enable), .i_chip_select(i_chip_select), .i_wr_enable(i_wr_enable),
        .i_wr_address(i_wr_address), .i_wr_data(i_wr_data), .i_vsync(i_vsync),
        .o_status(o_status), .o_display_offset(o_display_offset),
        .o_tre_reset(o_tre_reset), .o_tre_draw(o_tre_draw), .o_vtx(o_vtx),
        .i_tre_x(i_tre_x), .i_tre_y(i_tre_y),
        .i_tre_r(i_tre_r), .i_tre_g(i_tre_g), .i_tre_b(i_tre_b),
        .i_tre_write(i_tre_write), .i_tre_busy(i_tre_busy), .i_tre_done(i_tre_done),
        .o_wr_enable(o_wr_enable), .o_wr_address(o_wr_address),
        .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    function automatic logic [31:0] tri_val(input logic [31:0] seed, input int v, input int f);
        return seed + 32'h0101_0101 * 32'(v*5 + f + 1);
    endfunction

    // Expected bank: per vertex {a,b,g,r,v,u,z,y,x} from MSB down.
    function automatic logic [455:0] exp_tri(input logic [31:0] seed, input bit keep_col);
        logic [455:0] e;
        logic [31:0]  col, uv;
        e = '0;
        for (int v = 0; v < 3; v++) begin
            col = keep_col ? tri_val(seed, v, 3) : 32'h0;
            uv  = tri_val(seed, v, 4);
            e[v*152 +: 152] = {col[31:24], col[7:0], col[15:8], col[23:16],
                               uv[11:0], uv[27:16],
                               tri_val(seed, v, 2), tri_val(seed, v, 1), tri_val(seed, v, 0)};
        end
        return e;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic cs);
        i_enable = 1'b1; i_chip_select = cs; i_wr_enable = 1'b1;
        i_wr_address = a; i_wr_data = d;
        @(negedge i_clk);
        i_enable = 1'b0; i_chip_select = 1'b0; i_wr_enable = 1'b0;
    endtask

    task automatic stage_tri(input logic [31:0] seed);
        for (int v = 0; v < 3; v++)
            for (int f = 0; f < 5; f++)
                wr(32'(3 + v*5 + f), tri_val(seed, v, f), 1'b1);
    endtask

    task automatic pulse_done();
        i_tre_done = 1'b1;
        @(negedge i_clk);
        i_tre_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_tre_reset !== 1'b1) begin n_bad++; $display("FAIL reset_tre_reset got=%b exp=1", o_tre_reset); end
        n_cmp++; if (o_status !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h exp=0", o_status); end
        n_cmp++; if (o_vtx !== '0) begin n_bad++; $display("FAIL reset_vtx got=%h exp=0", o_vtx); end
        n_cmp++; if (o_display_offset !== 18'h0) begin n_bad++; $display("FAIL reset_disp got=%h exp=0", o_display_offset); end
        n_cmp++; if (o_wr_enable !== 1'b0 || o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL reset_strobes got=%b%b exp=00", o_wr_enable, o_tre_draw); end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_tre_reset !== 1'b0) begin n_bad++; $display("FAIL reset_release got=%b exp=0", o_tre_reset); end
    endtask

    task automatic test_status_busy();
        i_tre_busy = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_status !== 32'h1) begin n_bad++; $display("FAIL busy_set got=%h exp=1", o_status); end
        i_tre_busy = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_status !== 32'h0) begin n_bad++; $display("FAIL busy_clr got=%h exp=0", o_status); end
    endtask

    task automatic test_draw();
        wr(32'd1, 32'h1, 1'b1);
        stage_tri(SEED_A);
        wr(32'd18, 32'h100, 1'b1);
        wr(32'd2, 32'h0, 1'b1);
        n_cmp++; if (o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL draw_early got=%b exp=0", o_tre_draw); end
        n_cmp++; if (o_status !== 32'h8) begin n_bad++; $display("FAIL draw_pending got=%h exp=8", o_status); end
        @(negedge i_clk);
        n_cmp++; if (o_tre_draw !== 1'b1) begin n_bad++; $display("FAIL draw_kick got=%b exp=1", o_tre_draw); end
        n_cmp++; if (o_vtx !== exp_tri(SEED_A, 1'b1)) begin n_bad++; $display("FAIL draw_vtx got=%h exp=%h", o_vtx, exp_tri(SEED_A, 1'b1)); end
        n_cmp++; if (o_status !== 32'h2) begin n_bad++; $display("FAIL draw_kick_status got=%h exp=2", o_status); end
        @(negedge i_clk);
        n_cmp++; if (o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL draw_one_cycle got=%b exp=0", o_tre_draw); end
    endtask

    task automatic test_pixel();
        logic [15:0] px [6] = '{16'd5, 16'hFFFF, 16'd320, 16'd0, 16'd319, 16'd0};
        logic [15:0] py [6] = '{16'd2, 16'd0,    16'd0,   16'd240, 16'd239, 16'd0};
        logic        pen [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] pad [6] = '{18'h00385, 18'h0, 18'h0, 18'h0, 18'h12CFF, 18'h00100};
        for (int i = 0; i < 6; i++) begin
            i_tre_x = px[i]; i_tre_y = py[i];
            i_tre_r = 8'(i*16 + 1); i_tre_g = 8'(i + 2); i_tre_b = 8'(255 - i);
            i_tre_write = 1'b1;
            @(negedge i_clk);
            i_tre_write = 1'b0;
            n_cmp++; if (o_wr_enable !== pen[i]) begin n_bad++; $display("FAIL pix%0d_en got=%b exp=%b", i, o_wr_enable, pen[i]); end
            if (pen[i]) begin
                n_cmp++; if (o_wr_address !== pad[i]) begin n_bad++; $display("FAIL pix%0d_addr got=%h exp=%h", i, o_wr_address, pad[i]); end
                n_cmp++; if ({o_r, o_g, o_b} !== {8'(i*16 + 1), 8'(i + 2), 8'(255 - i)}) begin n_bad++; $display("FAIL pix%0d_rgb got=%h", i, {o_r, o_g, o_b}); end
            end
        end
        @(negedge i_clk);
        n_cmp++; if (o_wr_enable !== 1'b0) begin n_bad++; $display("FAIL pix_idle got=%b exp=0", o_wr_enable); end
    endtask

    task automatic test_back_to_back();
        stage_tri(SEED_B);
        wr(32'd2, 32'h0, 1'b1);
        n_cmp++; if (o_status !== 32'hA) begin n_bad++; $display("FAIL b2b_pending got=%h exp=a", o_status); end
        stage_tri(SEED_C);
        wr(32'd2, 32'h0, 1'b1);
        n_cmp++; if (o_status !== 32'h1A) begin n_bad++; $display("FAIL b2b_overflow got=%h exp=1a", o_status); end
        pulse_done();
        n_cmp++; if (o_status !== 32'h1A || o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%h/%b exp=1a/0", o_status, o_tre_draw); end
        @(negedge i_clk);
        n_cmp++; if (o_status !== 32'h1C || o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%h/%b exp=1c/0", o_status, o_tre_draw); end
        @(negedge i_clk);
        n_cmp++; if (o_tre_draw !== 1'b1) begin n_bad++; $display("FAIL b2b_kick got=%b exp=1", o_tre_draw); end
        n_cmp++; if (o_vtx !== exp_tri(SEED_B, 1'b1)) begin n_bad++; $display("FAIL b2b_vtx got=%h exp=%h", o_vtx, exp_tri(SEED_B, 1'b1)); end
        n_cmp++; if (o_status !== 32'h16) begin n_bad++; $display("FAIL b2b_kick_status got=%h exp=16", o_status); end
        @(negedge i_clk);
        pulse_done();
        @(negedge i_clk);
        n_cmp++; if (o_status !== 32'h14) begin n_bad++; $display("FAIL b2b_done got=%h exp=14", o_status); end
        wr(32'd0, 32'h0, 1'b1);
        n_cmp++; if (o_status !== 32'h10) begin n_bad++; $display("FAIL done_clear got=%h exp=10", o_status); end
    endtask

    task automatic test_colour_strip();
        wr(32'd1, 32'h0, 1'b1);
        stage_tri(SEED_D);
        wr(32'd6, 32'hFF11_2233, 1'b1);
        wr(32'd2, 32'h0, 1'b1);
        @(negedge i_clk);
        n_cmp++; if (o_tre_draw !== 1'b1) begin n_bad++; $display("FAIL strip_kick got=%b exp=1", o_tre_draw); end
        n_cmp++; if (o_vtx !== exp_tri(SEED_D, 1'b0)) begin n_bad++; $display("FAIL strip_vtx got=%h exp=%h", o_vtx, exp_tri(SEED_D, 1'b0)); end
        n_cmp++; if (o_status !== 32'h12) begin n_bad++; $display("FAIL strip_status got=%h exp=12", o_status); end
        @(negedge i_clk);
        pulse_done();
        @(negedge i_clk);
    endtask

    task automatic test_disp_offset();
        wr(32'd1, 32'h2, 1'b1);
        wr(32'd19, 32'h9600, 1'b1);
        n_cmp++; if (o_display_offset !== 18'h0) begin n_bad++; $display("FAIL flip_hold got=%h exp=0", o_display_offset); end
        repeat (2) @(negedge i_clk);
        n_cmp++; if (o_display_offset !== 18'h0) begin n_bad++; $display("FAIL flip_hold2 got=%h exp=0", o_display_offset); end
        i_vsync = 1'b1;
        @(negedge i_clk);
        i_vsync = 1'b0;
        n_cmp++; if (o_display_offset !== 18'h09600) begin n_bad++; $display("FAIL flip_vsync got=%h exp=9600", o_display_offset); end
        i_vsync = 1'b1;
        wr(32'd19, 32'h1234, 1'b1);
        i_vsync = 1'b0;
        n_cmp++; if (o_display_offset !== 18'h09600) begin n_bad++; $display("FAIL flip_same_cycle got=%h exp=9600", o_display_offset); end
        repeat (2) @(negedge i_clk);
        i_vsync = 1'b1;
        @(negedge i_clk);
        i_vsync = 1'b0;
        n_cmp++; if (o_display_offset !== 18'h01234) begin n_bad++; $display("FAIL flip_next got=%h exp=1234", o_display_offset); end
        wr(32'd1, 32'h0, 1'b1);
        wr(32'd19, 32'h42, 1'b1);
        n_cmp++; if (o_display_offset !== 18'h00042) begin n_bad++; $display("FAIL direct_disp got=%h exp=42", o_display_offset); end
    endtask

    task automatic test_soft_reset();
        wr(32'd1, 32'h1, 1'b1);
        stage_tri(SEED_E);
        wr(32'd2, 32'h0, 1'b1);
        repeat (2) @(negedge i_clk);
        wr(32'd2, 32'h0, 1'b1);
        wr(32'd2, 32'h0, 1'b1);
        n_cmp++; if (o_status !== 32'h1A) begin n_bad++; $display("FAIL srst_pre got=%h exp=1a", o_status); end
        wr(32'd0, 32'h1, 1'b0);
        n_cmp++; if (o_status !== 32'h1A || o_tre_reset !== 1'b0) begin n_bad++; $display("FAIL srst_nocs got=%h/%b exp=1a/0", o_status, o_tre_reset); end
        wr(32'd0, 32'h1, 1'b1);
        n_cmp++; if (o_tre_reset !== 1'b1) begin n_bad++; $display("FAIL srst_tre_reset got=%b exp=1", o_tre_reset); end
        n_cmp++; if (o_status !== 32'h0) begin n_bad++; $display("FAIL srst_status got=%h exp=0", o_status); end
        n_cmp++; if (o_vtx !== '0 || o_display_offset !== 18'h0) begin n_bad++; $display("FAIL srst_banks vtx_nonzero=%b disp=%h exp=0/0", |o_vtx, o_display_offset); end
        @(negedge i_clk);
        n_cmp++; if (o_tre_reset !== 1'b0) begin n_bad++; $display("FAIL srst_release got=%b exp=0", o_tre_reset); end
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_status !== 32'h0 || o_tre_draw !== 1'b0) begin n_bad++; $display("FAIL srst_no_kick got=%h/%b exp=0/0", o_status, o_tre_draw); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge i_clk);
        test_reset();
        test_status_busy();
        test_draw();
        test_pixel();
        test_back_to_back();
        test_colour_strip();
        test_disp_offset();
        test_soft_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
